ahblite_irq_ctrl: RTL and testbench

AHB-Lite slave that collects interrupt requests from peripheral slaves, including timer_irq from the timer slave, and drives the Cortex-M0 IRQ inputs. Each source is latched into a pending bit, gated by a per-source enable, and cleared by software with write-1-to-clear. Each source is selectable as edge-triggered (single-cycle pulses such as the timer) or level-triggered. It sits on the AHB-Lite matrix alongside the other slaves; irq_out connects to the core's IRQ bus.

---
 rtl/ahblite_irq_ctrl.sv | 127 ++++++++++++
 tb/tb_ahblite_irq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ahblite_irq_ctrl.sv
// AHB-Lite interrupt controller: pending/enable/mode registers feeding Cortex-M0 IRQ lines.
// Define IRQ_SYNC_EN to pass irq_src through a two-flop synchronizer (latency 3 instead of 1).
module ahblite_irq_ctrl #(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HSIZE,
    input  logic [3:0]         HPROT,
    input  logic               HWRITE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic [31:0]        HRDATA,
    output logic               HRESP,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic [NUM_IRQ-1:0] irq_out
);
    localparam int unsigned AW = 2;
    localparam logic [AW-1:0] A_PEND   = 2'd0;
    localparam logic [AW-1:0] A_ENABLE = 2'd1;
    localparam logic [AW-1:0] A_MODE   = 2'd2;
    localparam logic [AW-1:0] A_RAW    = 2'd3;

    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] s_c;
    logic [NUM_IRQ-1:0] set_c;
    logic [NUM_IRQ-1:0] clr_c;
    logic               unused_c;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign unused_c  = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous request lines
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end
    assign s_c = sync2_q;
`else
    assign s_c = irq_src;
`endif

    // Next-state: address-phase capture, register writes, pending set/clear
    always_comb begin
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        addr_d   = addr_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        clr_c    = '0;

        if (HSEL && HREADY && HTRANS[1]) begin
            wr_en_d = HWRITE;
            rd_en_d = !HWRITE;
            addr_d  = HADDR[3:2];
        end

        if (wr_en_q) begin
            case (addr_q)
                A_PEND:   clr_c    = HWDATA[NUM_IRQ-1:0];
                A_ENABLE: enable_d = HWDATA[NUM_IRQ-1:0];
                A_MODE:   mode_d   = HWDATA[NUM_IRQ-1:0];
                default:  ;
            endcase
        end

        // Level sources set every cycle they are high; edge sources only on 0->1
        set_c  = (mode_q & s_c) | (~mode_q & s_c & ~prev_q);
        pend_d = set_c | (pend_q & ~clr_c);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            pend_q   <= '0;
            enable_q <= '0;
            mode_q   <= '0;
            prev_q   <= '0;
        end else begin
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            pend_q   <= pend_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            prev_q   <= s_c;
        end
    end

    // Read mux: data-phase read of the register selected in the address phase
    always_comb begin
        HRDATA = '0;
        if (rd_en_q) begin
            case (addr_q)
                A_PEND:   HRDATA = 32'(pend_q);
                A_ENABLE: HRDATA = 32'(enable_q);
                A_MODE:   HRDATA = 32'(mode_q);
                A_RAW:    HRDATA = 32'(s_c);
                default:  HRDATA = '0;
            endcase
        end
    end

    assign irq_out = pend_q & enable_q;

endmodule

// File: tb/tb_ahblite_irq_ctrl.sv
// Directed self-checking bench for ahblite_irq_ctrl (NUM_IRQ=4); honours IRQ_SYNC_EN latency.
module tb_ahblite_irq_ctrl;
`ifdef IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [3:0]  irq_src;
    logic [3:0]  irq_out;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;

    ahblite_irq_ctrl #(.NUM_IRQ(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .irq_src(irq_src), .irq_out(irq_out)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1);
        HWDATA = d;
        tick();
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        addr_phase(a, 1'b0);
        d = HRDATA;
        tick();
    endtask

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = '0; HSIZE = 3'd2;
        HPROT = '0; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1; irq_src = '0;
        #12 HRESETn = 1'b1;
        tick();

        // Reset state
        ahb_read(32'h0, rd); check("rst_pend", rd, 32'h0);
        ahb_read(32'h4, rd); check("rst_enable", rd, 32'h0);
        ahb_read(32'h8, rd); check("rst_mode", rd, 32'h0);
        ahb_read(32'hC, rd); check("rst_raw", rd, 32'h0);
        check("rst_irq_out", 32'(irq_out), 32'h0);
        check("hreadyout", 32'(HREADYOUT), 32'h1);
        check("hresp", 32'(HRESP), 32'h0);

        // Edge mode: 1-cycle pulse on source 0
        ahb_write(32'h4, 32'h1);
        ahb_write(32'h8, 32'h0);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        repeat (LAT - 1) tick();
        check("edge_irq_out", 32'(irq_out), 32'h1);
        ahb_read(32'h0, rd); check("edge_pend", rd, 32'h1);
        ahb_write(32'h0, 32'h1);
        check("w1c_irq_out", 32'(irq_out), 32'h0);

        // Held high 10 cycles: only one set
        irq_src[0] = 1'b1;
        repeat (10) tick();
        ahb_read(32'h0, rd); check("hold_pend", rd, 32'h1);
        ahb_write(32'h0, 32'h1);
        ahb_read(32'h0, rd); check("hold_no_repend", rd, 32'h0);
        irq_src[0] = 1'b0;
        repeat (4) tick();

        // Level mode on source 1
        ahb_write(32'h8, 32'h2);
        ahb_write(32'h4, 32'h2);
        irq_src[1] = 1'b1;
        repeat (LAT + 1) tick();
        check("lvl_irq_out", 32'(irq_out), 32'h2);
        ahb_write(32'h0, 32'h2);
        ahb_read(32'h0, rd); check("lvl_repend", rd, 32'h2);
        irq_src[1] = 1'b0;
        repeat (LAT + 1) tick();
        ahb_write(32'h0, 32'h2);
        ahb_read(32'h0, rd); check("lvl_cleared", rd, 32'h0);
        repeat (3) tick();
        ahb_read(32'h0, rd); check("lvl_stays_clr", rd, 32'h0);
        ahb_read(32'h8, rd); check("mode_rb", rd, 32'h2);

        // Disabled source still pends; enabling asserts irq_out
        ahb_write(32'h4, 32'h0);
        irq_src[2] = 1'b1;
        tick();
        irq_src[2] = 1'b0;
        repeat (LAT + 1) tick();
        ahb_read(32'h0, rd); check("dis_pend", rd, 32'h4);
        check("dis_irq_out", 32'(irq_out), 32'h0);
        ahb_write(32'h4, 32'h4);
        check("en_late_irq_out", 32'(irq_out), 32'h4);
        ahb_write(32'h0, 32'h4);
        check("en_late_clr", 32'(irq_out), 32'h0);
        repeat (4) tick();

        // Rising edge coincides with W1C data phase: set wins
`ifdef IRQ_SYNC_EN
        irq_src[0] = 1'b1;
        tick();
        addr_phase(32'h0, 1'b1);
        HWDATA = 32'h1;
        tick();
`else
        addr_phase(32'h0, 1'b1);
        HWDATA = 32'h1;
        irq_src[0] = 1'b1;
        tick();
`endif
        ahb_read(32'h0, rd); check("set_wins", rd, 32'h1);
        irq_src[0] = 1'b0;
        repeat (4) tick();

        // Exact source-to-irq_out latency on source 3
        ahb_write(32'h4, 32'h8);
        irq_src[3] = 1'b1;
        repeat (LAT - 1) tick();
        check("lat_before", 32'(irq_out), 32'h0);
        tick();
        check("lat_at", 32'(irq_out), 32'h8);
        repeat (2) tick();
        ahb_read(32'hC, rd); check("raw_rb", rd, 32'h8);
        ahb_write(32'hC, 32'hFFFF_FFFF);
        ahb_read(32'hC, rd); check("raw_ro", rd, 32'h8);
        ahb_read(32'h4, rd); check("raw_wr_no_side", rd, 32'h8);

        // Asynchronous reset mid-read with irq_out active, source 3 held high
        ahb_write(32'h4, 32'hF);
        check("pre_rst_irq_out", 32'(irq_out), 32'h9);
        addr_phase(32'h0, 1'b0);
        check("pre_rst_hrdata", HRDATA, 32'h9);
        HRESETn = 1'b0;
        #1;
        check("rst_async_irq_out", 32'(irq_out), 32'h0);
        check("rst_async_hrdata", HRDATA, 32'h0);
        #5 HRESETn = 1'b1;
        tick();
        ahb_read(32'h4, rd); check("post_rst_enable", rd, 32'h0);
        ahb_read(32'h8, rd); check("post_rst_mode", rd, 32'h0);
        // prev was cleared, so the still-high source re-pends in edge mode
        ahb_read(32'h0, rd); check("post_rst_pend", rd, 32'h8);
        check("post_rst_irq_out", 32'(irq_out), 32'h0);
        check("hreadyout_end", 32'(HREADYOUT), 32'h1);
        check("hresp_end", 32'(HRESP), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
